nios_system_pio_edge: RTL and testbench

Parametrised Avalon-MM slave general-purpose I/O port for the Nios II system: a DATA_WIDTH-bit output register with atomic bit set/clear, plus a DATA_WIDTH-bit input port with two-flop synchronisation, per-bit edge capture and a maskable interrupt. It sits on the Nios data master's Avalon fabric and replaces single-register output-only PIOs where software needs input sensing or glitch-free bit manipulation.

---
 rtl/nios_pio_pkg.sv | 18 +
 rtl/pio_sync_edge.sv | 63 ++++++
 rtl/nios_system_pio_edge.sv | 137 +++++++++++++
 tb/tb_nios_system_pio_edge.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios_pio_pkg.sv
// nios_pio_pkg
// Shared constants for the Nios II edge-capturing PIO:
//   - word offsets of the Avalon-MM register map
//   - EDGE_TYPE encodings selecting which input transitions are captured
package nios_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_OUTDATA = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge
// Three-flop input stage for asynchronous pins.  s1/s2 form the
// metastability synchroniser; s3 is a one-cycle delayed copy of s2 used
// only to detect transitions of the synchronised value.
// Parameters:
//   DATA_WIDTH  number of input bits
//   EDGE_TYPE   EDGE_RISE / EDGE_FALL / EDGE_ANY (see nios_pio_pkg)
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   din          asynchronous inputs
//   sync_out     synchronised inputs (s2)
//   edge_out     one-cycle pulse per bit on a selected transition
module pio_sync_edge
    import nios_pio_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int EDGE_TYPE  = EDGE_RISE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] sync_out,
    output logic [DATA_WIDTH-1:0] edge_out
);

    logic [DATA_WIDTH-1:0] s1_q, s1_d;
    logic [DATA_WIDTH-1:0] s2_q, s2_d;
    logic [DATA_WIDTH-1:0] s3_q, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign sync_out = s2_q;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_edge
            if (EDGE_TYPE == EDGE_FALL) begin : g_fall
                assign edge_out[gi] = ~s2_q[gi] & s3_q[gi];
            end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
                assign edge_out[gi] = s2_q[gi] ^ s3_q[gi];
            end else begin : g_rise
                assign edge_out[gi] = s2_q[gi] & ~s3_q[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/nios_system_pio_edge.sv
// nios_system_pio_edge
// Avalon-MM slave GPIO: output register with atomic set/clear, synchronised
// input port with per-bit edge capture and a maskable level interrupt.
// Register map (word offsets): 0 DATA, 1 OUTDATA, 2 IRQMASK, 3 EDGECAP
// (write-1-to-clear), 4 OUTSET, 5 OUTCLR, 6/7 reserved (read 0).
// Build option: define PIO_IRQ_EN to implement IRQMASK and drive irq;
// without it IRQMASK reads 0 and irq is tied low, edge capture still works.
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   address, chipselect,
//   write_n, writedata     Avalon-MM slave write/read request
//   readdata               zero-latency read data, zero-extended
//   in_port                asynchronous inputs
//   out_port               registered outputs
//   irq                    level interrupt
module nios_system_pio_edge
    import nios_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    EDGE_TYPE   = EDGE_RISE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] in_sync;
    logic [DATA_WIDTH-1:0] in_edge;
    logic [DATA_WIDTH-1:0] mask_view;
    logic [DATA_WIDTH-1:0] rd_val;

    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;

    assign wr_en = chipselect & ~write_n;
    assign wdata = writedata[DATA_WIDTH-1:0];

    generate
        if (DATA_WIDTH < 32) begin : g_unused_wdata
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^writedata[31:DATA_WIDTH];
        end
    endgenerate

    pio_sync_edge #(
        .DATA_WIDTH(DATA_WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .din     (in_port),
        .sync_out(in_sync),
        .edge_out(in_edge)
    );

    always_comb begin
        out_d = out_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   out_d = wdata;
                ADDR_OUTSET: out_d = out_q | wdata;
                ADDR_OUTCLR: out_d = out_q & ~wdata;
                default:     out_d = out_q;
            endcase
        end
    end

    // Clear is applied first and the new edge ORed in afterwards, so an
    // edge arriving on the same clock as a clear keeps the bit set.
    always_comb begin
        cap_d = cap_q;
        if (wr_en && (address == ADDR_EDGECAP)) begin
            cap_d = cap_q & ~wdata;
        end
        cap_d = cap_d | in_edge;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= RESET_VALUE;
            cap_q <= '0;
        end else begin
            out_q <= out_d;
            cap_q <= cap_d;
        end
    end

`ifdef PIO_IRQ_EN
    logic [DATA_WIDTH-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            mask_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask_view = mask_q;
    assign irq       = |(cap_q & mask_q);
`else
    assign mask_view = '0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_DATA:    rd_val = in_sync;
            ADDR_OUTDATA: rd_val = out_q;
            ADDR_IRQMASK: rd_val = mask_view;
            ADDR_EDGECAP: rd_val = cap_q;
            default:      rd_val = '0;
        endcase
    end

    assign readdata = 32'(rd_val);
    assign out_port = out_q;

endmodule

// File: tb/tb_nios_system_pio_edge.sv
// tb_nios_system_pio_edge
// Two instances share one bus: dut_a (EDGE_TYPE rising, RESET_VALUE A5)
// and dut_b (EDGE_TYPE any, RESET_VALUE 0), selected by 'sel'.
// Expected values are pushed to a scoreboard queue as each step is driven
// and popped when the corresponding DUT output is sampled.
module tb_nios_system_pio_edge;

`ifdef PIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        cs = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic        sel = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;

    logic        cs_a, cs_b;
    logic [31:0] rd_a, rd_b, rd_sel;
    logic [7:0]  out_a, out_b, out_sel;
    logic        irq_a, irq_b, irq_sel;

    assign cs_a    = cs & ~sel;
    assign cs_b    = cs & sel;
    assign rd_sel  = sel ? rd_b : rd_a;
    assign out_sel = sel ? out_b : out_a;
    assign irq_sel = sel ? irq_b : irq_a;

    always #5 clk = ~clk;

    nios_system_pio_edge #(
        .DATA_WIDTH (8),
        .RESET_VALUE(8'hA5),
        .EDGE_TYPE  (0)
    ) dut_a (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(cs_a),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (rd_a),
        .in_port   (in_a),
        .out_port  (out_a),
        .irq       (irq_a)
    );

    nios_system_pio_edge #(
        .DATA_WIDTH (8),
        .RESET_VALUE(8'h00),
        .EDGE_TYPE  (2)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(cs_b),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (rd_b),
        .in_port   (in_b),
        .out_port  (out_b),
        .irq       (irq_b)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic sb_push(input string tag, input logic [31:0] val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: observed=%h expected=<entry>", obs);
        end else begin
            e = sb_q.pop_front();
            $display("txn %s obs=%h exp=%h", e.tag, obs, e.val);
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance one clock; returns at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        cs        = 1'b1;
        write_n   = 1'b0;
        tick();
        cs        = 1'b0;
        write_n   = 1'b1;
        writedata = '0;
    endtask

    task automatic check_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
        sb_push(tag, exp);
        address = a;
        cs      = 1'b1;
        write_n = 1'b1;
        #1;
        sb_check(rd_sel);
        cs = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp);
        sb_push(tag, 32'(exp));
        sb_check(32'(out_sel));
    endtask

    task automatic check_irq(input string tag, input logic exp);
        sb_push(tag, 32'(exp));
        sb_check(32'(irq_sel));
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        sel = 1'b0;
        check_out("rst_out_a", 8'hA5);
        check_read("rst_outdata_a", 3'd1, 32'h0000_00A5);
        check_read("rst_edgecap_a", 3'd3, 32'h0);
        check_irq("rst_irq_a", 1'b0);
        check_read("rst_irqmask_a", 3'd2, 32'h0);

        // Output register load / set / clear on successive cycles
        bus_write(3'd0, 32'hFFFF_FF3C);
        check_out("out_load", 8'h3C);
        bus_write(3'd4, 32'h0000_0081);
        check_out("out_set", 8'hBD);
        bus_write(3'd5, 32'h0000_000C);
        check_out("out_clr", 8'hB1);
        check_read("outdata_rb", 3'd1, 32'h0000_00B1);
        check_read("outset_rd0", 3'd4, 32'h0);
        check_read("outclr_rd0", 3'd5, 32'h0);
        check_read("addr6_rd0", 3'd6, 32'h0);
        bus_write(3'd1, 32'h0000_0000);
        check_out("outdata_wr_ignored", 8'hB1);

        // Rising-edge capture latency on bit0
        bus_write(3'd2, 32'h0000_0001);
        check_read("irqmask_rb", 3'd2, IRQ_EN ? 32'h1 : 32'h0);
        in_a = 8'h01;
        tick(); // E0
        check_read("data_after_e0", 3'd0, 32'h0);
        tick(); // E1
        check_read("data_after_e1", 3'd0, 32'h1);
        check_read("cap_after_e1", 3'd3, 32'h0);
        check_irq("irq_after_e1", 1'b0);
        tick(); // E2
        check_read("cap_after_e2", 3'd3, 32'h1);
        check_irq("irq_after_e2", IRQ_EN);

        // Clear, then a falling edge must not capture
        bus_write(3'd3, 32'h0000_0001);
        check_read("cap_cleared", 3'd3, 32'h0);
        check_irq("irq_cleared", 1'b0);
        in_a = 8'h00;
        repeat (4) tick();
        check_read("fall_no_cap", 3'd3, 32'h0);
        check_read("data_low", 3'd0, 32'h0);

        // Clear coinciding with a new rising edge: set wins
        in_a = 8'h01;
        tick(); // E0
        tick(); // E1
        bus_write(3'd3, 32'h0000_0001); // lands on E2
        check_read("cap_set_wins", 3'd3, 32'h1);
        check_irq("irq_set_wins", IRQ_EN);
        bus_write(3'd3, 32'h0000_0001);
        check_read("cap_clear2", 3'd3, 32'h0);
        check_irq("irq_clear2", 1'b0);

        // Any-edge instance: two toggles of bit3 with mask 0
        sel = 1'b1;
        #1;
        check_out("rst_out_b", 8'h00);
        in_b = 8'h08;
        tick();
        tick();
        in_b = 8'h00;
        repeat (4) tick();
        check_read("any_cap_b", 3'd3, 32'h0000_0008);
        check_irq("any_irq_masked", 1'b0);
        bus_write(3'd2, 32'h0000_0008);
        check_irq("any_irq_unmasked", IRQ_EN);
        check_read("irqmask_b", 3'd2, IRQ_EN ? 32'h8 : 32'h0);
        bus_write(3'd2, 32'h0000_00FF);
        check_read("irqmask_ff", 3'd2, IRQ_EN ? 32'hFF : 32'h0);
        check_irq("irq_mask_ff", IRQ_EN);
        bus_write(3'd3, 32'h0000_00FF);
        check_read("cap_b_cleared", 3'd3, 32'h0);
        check_irq("irq_b_cleared", 1'b0);

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
